// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bus for bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, neg, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, neg, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Optional leading-zero blanking enabled by defining BCD_LEAD_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W     = 8,
  parameter int DIGITS    = 3,
  parameter int SIGNED_IN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int SW = 4*DIGITS + 4;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_scratch;
  logic [BIN_W-1:0]    r_mag;
  logic [CW-1:0]       r_cnt;
  logic                r_neg_i;
  logic                r_busy;
  logic                r_done;
  logic                r_neg;
  logic                r_ovf;
  logic [4*DIGITS-1:0] r_bcd;

  logic                w_in_neg;
  logic [BIN_W-1:0]    w_in_mag;
  logic [SW-1:0]       w_adj;
  logic                w_ovf;
  logic [4*DIGITS-1:0] w_digits;

  // Magnitude keeps BIN_W bits, so the most negative input maps to 2^(BIN_W-1).
  assign w_in_neg = (SIGNED_IN != 0) && bus.bin_in[BIN_W-1];
  assign w_in_mag = w_in_neg ? (-bus.bin_in) : bus.bin_in;

  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
`ifdef BCD_LEAD_ZERO_BLANK_EN
    logic w_lead;
`endif
    w_ovf = (r_scratch[SW-1 -: 4] != 4'd0);
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scratch[4*k +: 4] > 4'd9) begin
        w_ovf = 1'b1;
      end
    end
    w_digits = r_scratch[4*DIGITS-1:0];
`ifdef BCD_LEAD_ZERO_BLANK_EN
    w_lead = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      if (w_lead && (r_scratch[4*k +: 4] == 4'd0)) begin
        w_digits[4*k +: 4] = 4'hF;
      end else begin
        w_lead = 1'b0;
      end
    end
`endif
    // Overflow blanks every digit regardless of zero blanking.
    if (w_ovf) begin
      w_digits = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_scratch <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_neg_i   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mag     <= w_in_mag;
            r_neg_i   <= w_in_neg;
            r_scratch <= '0;
            r_cnt     <= CW'(BIN_W);
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_mag} <= {w_adj, r_mag} << 1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= w_digits;
          r_neg   <= r_neg_i;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd;
  assign bus.neg     = r_neg;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard bench driving signed/3-digit, unsigned/3-digit and unsigned/2-digit converters in parallel
module tb_bin_to_bcd_seq;

`ifdef BCD_LEAD_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tb_start;
  logic [7:0] tb_bin;
  int         n_chk;
  int         n_err;
  int         cyc;
  int         last_done_a;
  int         prev_done_a;
  exp_t       q_a[$];
  exp_t       q_b[$];
  exp_t       q_c[$];
  exp_t       e_a, e_b, e_c;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if_a ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if_b ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if_c ();

  assign if_a.start  = tb_start;
  assign if_a.bin_in = tb_bin;
  assign if_b.start  = tb_start;
  assign if_b.bin_in = tb_bin;
  assign if_c.start  = tb_start;
  assign if_c.bin_in = tb_bin;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED_IN(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED_IN(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED_IN(0)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got done pulse expected none", name);
  endtask

  function automatic logic [11:0] blk(input logic [11:0] d, input int nd);
    logic [11:0] r;
    r = d;
    if (BLANK) begin
      for (int k = nd - 1; k > 0; k--) begin
        if (r[4*k +: 4] == 4'h0) r[4*k +: 4] = 4'hF;
        else break;
      end
    end
    return r;
  endfunction

  task automatic push(input logic [11:0] ea, input logic na, input logic [11:0] eb,
                      input logic [7:0] ec, input logic oc);
    exp_t x;
    x = '{bcd: blk(ea, 3), neg: na, ovf: 1'b0};
    q_a.push_back(x);
    x = '{bcd: blk(eb, 3), neg: 1'b0, ovf: 1'b0};
    q_b.push_back(x);
    x = '{bcd: (oc ? 12'h0FF : blk({4'h0, ec}, 2)), neg: 1'b0, ovf: oc};
    q_c.push_back(x);
  endtask

  task automatic conv(input logic [7:0] v, input logic [11:0] ea, input logic na,
                      input logic [11:0] eb, input logic [7:0] ec, input logic oc);
    push(ea, na, eb, ec, oc);
    @(negedge clk);
    tb_bin   = v;
    tb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (if_a.done) begin
      if (q_a.size() == 0) unexpected("a_done");
      else begin
        e_a = q_a.pop_front();
        chk("a_bcd", 32'(if_a.bcd_out), 32'(e_a.bcd));
        chk("a_neg", 32'(if_a.neg), 32'(e_a.neg));
        chk("a_ovf", 32'(if_a.ovf), 32'(e_a.ovf));
      end
      prev_done_a = last_done_a;
      last_done_a = cyc;
    end
  end

  always @(negedge clk) begin
    if (if_b.done) begin
      if (q_b.size() == 0) unexpected("b_done");
      else begin
        e_b = q_b.pop_front();
        chk("b_bcd", 32'(if_b.bcd_out), 32'(e_b.bcd));
        chk("b_neg", 32'(if_b.neg), 32'(e_b.neg));
        chk("b_ovf", 32'(if_b.ovf), 32'(e_b.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (if_c.done) begin
      if (q_c.size() == 0) unexpected("c_done");
      else begin
        e_c = q_c.pop_front();
        chk("c_bcd", 32'(if_c.bcd_out), 32'(e_c.bcd[7:0]));
        chk("c_neg", 32'(if_c.neg), 32'(e_c.neg));
        chk("c_ovf", 32'(if_c.ovf), 32'(e_c.ovf));
      end
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    last_done_a = 0;
    prev_done_a = 0;
    tb_start = 1'b0;
    tb_bin   = 8'h00;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_a_bcd",  32'(if_a.bcd_out), 32'h000);
    chk("rst_a_busy", 32'(if_a.busy), 32'd0);
    chk("rst_a_done", 32'(if_a.done), 32'd0);
    chk("rst_a_neg",  32'(if_a.neg), 32'd0);
    chk("rst_a_ovf",  32'(if_a.ovf), 32'd0);
    chk("rst_c_bcd",  32'(if_c.bcd_out), 32'h00);

    // Latency: accept at edge 0, busy through edge 8, done only after edge 9.
    push(12'h001, 1'b1, 12'h255, 8'h00, 1'b1);
    @(negedge clk);
    tb_bin   = 8'hFF;
    tb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("busy_e%0d", k), 32'(if_a.busy), 32'd1);
      chk($sformatf("done_e%0d", k), 32'(if_a.done), 32'd0);
    end
    @(negedge clk);
    chk("done_e9", 32'(if_a.done), 32'd1);
    chk("busy_e9", 32'(if_a.busy), 32'd0);
    @(negedge clk);
    chk("done_e10", 32'(if_a.done), 32'd0);

    conv(8'hF6, 12'h010, 1'b1, 12'h246, 8'h00, 1'b1);
    conv(8'h80, 12'h128, 1'b1, 12'h128, 8'h00, 1'b1);
    conv(8'd100, 12'h100, 1'b0, 12'h100, 8'h00, 1'b1);
    conv(8'd99, 12'h099, 1'b0, 12'h099, 8'h99, 1'b0);
    conv(8'd9, 12'h009, 1'b0, 12'h009, 8'h09, 1'b0);
    conv(8'h00, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0);
    conv(8'h7F, 12'h127, 1'b0, 12'h127, 8'h00, 1'b1);
    conv(8'h81, 12'h127, 1'b1, 12'h129, 8'h00, 1'b1);
    conv(8'd42, 12'h042, 1'b0, 12'h042, 8'h42, 1'b0);

    repeat (5) @(negedge clk);
    chk("hold_a_bcd", 32'(if_a.bcd_out), 32'(blk(12'h042, 3)));
    chk("hold_c_bcd", 32'(if_c.bcd_out), 32'(blk(12'h042, 2)));

    // A start pulse mid-conversion must not queue a second result.
    push(12'h007, 1'b0, 12'h007, 8'h07, 1'b0);
    @(negedge clk);
    tb_bin   = 8'd7;
    tb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_start = 1'b0;
    repeat (2) @(negedge clk);
    tb_bin   = 8'd42;
    tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_start_q", 32'(q_a.size()), 32'd0);

    // Start held high: second accept lands in the done cycle.
    push(12'h007, 1'b0, 12'h007, 8'h07, 1'b0);
    push(12'h042, 1'b0, 12'h042, 8'h42, 1'b0);
    @(negedge clk);
    tb_bin   = 8'd7;
    tb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_bin = 8'd42;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tb_start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_spacing", 32'(last_done_a - prev_done_a), 32'd10);

    conv(8'hF6, 12'h010, 1'b1, 12'h246, 8'h00, 1'b1);

    // Abort mid-conversion with an asynchronous reset.
    @(negedge clk);
    tb_bin   = 8'd99;
    tb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_a_bcd",  32'(if_a.bcd_out), 32'h000);
    chk("abort_a_neg",  32'(if_a.neg), 32'd0);
    chk("abort_a_busy", 32'(if_a.busy), 32'd0);
    chk("abort_a_done", 32'(if_a.done), 32'd0);
    chk("abort_c_ovf",  32'(if_c.ovf), 32'd0);
    chk("abort_c_bcd",  32'(if_c.bcd_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_busy", 32'(if_a.busy), 32'd0);

    conv(8'd99, 12'h099, 1'b0, 12'h099, 8'h99, 1'b0);

    repeat (3) @(negedge clk);
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);
    chk("drain_c", 32'(q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
